// File: rtl/ntt_batch_sequencer_pkg.sv
// ntt_batch_sequencer_pkg: shared FSM encoding, default sizes and core address-width rule
package ntt_batch_sequencer_pkg;
   localparam int LOGN_DEF  = 12;
   localparam int LOGQ_DEF  = 64;
   localparam int NPOLY_DEF = 8;
   typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_RUN, S_GAP, S_DONE} state_e;
   function automatic int core_aw(input int logn);
      return (logn < 9) ? 10 : logn;
   endfunction
endpackage

// File: rtl/ntt_finish_monitor.sv
// ntt_finish_monitor: core_finish rising-edge detector and per-polynomial RUN watchdog
// Ports: clk, rst (sync, active-low), run_i (sequencer in RUN), core_finish_i (core done level),
//        finish_rise_o (0->1 this cycle), timeout_o (last RUN cycle allowed before TIMEOUT is reached)
module ntt_finish_monitor #(
   parameter int TIMEOUT = 2**20
) (
   input  logic clk,
   input  logic rst,
   input  logic run_i,
   input  logic core_finish_i,
   output logic finish_rise_o,
   output logic timeout_o
);
   localparam int WW = $clog2(TIMEOUT + 1);
   logic          fin_q;
   logic [WW-1:0] wd_q;
   always_ff @(posedge clk)
      if (!rst) begin
         fin_q <= 1'b0;
         wd_q  <= '0;
      end else begin
         fin_q <= core_finish_i;
         wd_q  <= run_i ? wd_q + WW'(1) : '0;
      end
   assign finish_rise_o = core_finish_i & ~fin_q;
   // wd_q holds RUN cycles already spent, so TIMEOUT-1 marks the TIMEOUT-th RUN cycle
   assign timeout_o = run_i && (wd_q == WW'(TIMEOUT - 1));
endmodule

// File: rtl/ntt_batch_sequencer.sv
// ntt_batch_sequencer: runs a batch of polynomials one at a time through an NTT memory-wrapper core
// Ports: clk, rst (sync, active-low); start_i/abort_i/npoly_i/mode_mask_i batch control;
//        core_* handshake and address/data to the core; mem_* banked batch memory ({poly, addr});
//        busy_o/done_o/error_o/poly_idx_o/cycles_o status
module ntt_batch_sequencer
   import ntt_batch_sequencer_pkg::*;
#(
   parameter int LOGN    = LOGN_DEF,
   parameter int LOGQ    = LOGQ_DEF,
   parameter int NPOLY   = NPOLY_DEF,
   parameter int TIMEOUT = 2**20
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            start_i,
   input  logic                            abort_i,
   input  logic [$clog2(NPOLY):0]          npoly_i,
   input  logic [NPOLY-1:0]                mode_mask_i,
   output logic                            core_start_o,
   output logic                            core_intt_o,
   input  logic [core_aw(LOGN)-1:0]        core_raddr_i,
   input  logic [core_aw(LOGN)-1:0]        core_waddr_i,
   input  logic                            core_wea_i,
   input  logic                            core_finish_i,
   output logic [LOGQ-1:0]                 core_din_o,
   input  logic [LOGQ-1:0]                 core_dout_i,
   output logic [$clog2(NPOLY)+core_aw(LOGN)-1:0] mem_raddr_o,
   output logic [$clog2(NPOLY)+core_aw(LOGN)-1:0] mem_waddr_o,
   output logic                            mem_we_o,
   input  logic [LOGQ-1:0]                 mem_rdata_i,
   output logic [LOGQ-1:0]                 mem_wdata_o,
   output logic                            busy_o,
   output logic                            done_o,
   output logic                            error_o,
   output logic [$clog2(NPOLY)-1:0]        poly_idx_o,
   output logic [63:0]                     cycles_o
);
   localparam int PW = $clog2(NPOLY);
   state_e          state_q;
   logic            start_q, intt_q, busy_q, done_q, error_q;
   logic [PW-1:0]   idx_q, idx_inc;
   logic [PW:0]     npoly_q;
   logic [NPOLY-1:0] mode_q;
   logic [63:0]     cycles_q;
   logic            rise, timeout, last, nz, fail;
   ntt_finish_monitor #(.TIMEOUT(TIMEOUT)) u_mon (
      .clk           (clk),
      .rst           (rst),
      .run_i         (state_q == S_RUN),
      .core_finish_i (core_finish_i),
      .finish_rise_o (rise),
      .timeout_o     (timeout)
   );
   assign idx_inc = idx_q + PW'(1);
   assign last    = {1'b0, idx_q} == npoly_q - (PW+1)'(1);
   assign nz      = npoly_i != '0;
   // a finish edge in the same cycle as the watchdog expiry still counts as success
   assign fail    = busy_q && (abort_i || (timeout && !rise));
   always_ff @(posedge clk)
      if (!rst) begin
         state_q  <= S_IDLE;
         start_q  <= 1'b0;
         intt_q   <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         error_q  <= 1'b0;
         idx_q    <= '0;
         npoly_q  <= '0;
         mode_q   <= '0;
         cycles_q <= '0;
      end else begin
         done_q <= 1'b0;
         if (busy_q) cycles_q <= cycles_q + 64'd1;
         if (fail) begin
            state_q <= S_DONE;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            error_q <= 1'b1;
         end else
            case (state_q)
               S_IDLE: if (start_i) begin
                  npoly_q  <= npoly_i;
                  mode_q   <= mode_mask_i;
                  cycles_q <= '0;
                  idx_q    <= '0;
                  error_q  <= 1'b0;
                  intt_q   <= mode_mask_i[0];
                  start_q  <= nz;
                  busy_q   <= nz;
                  done_q   <= !nz;
                  state_q  <= nz ? S_LAUNCH : S_DONE;
               end
               S_LAUNCH: state_q <= S_RUN;
               S_RUN: if (rise) begin
                  state_q <= S_GAP;
                  start_q <= 1'b0;
               end
               S_GAP: if (last) begin
                  state_q <= S_DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end else begin
                  state_q <= S_LAUNCH;
                  start_q <= 1'b1;
                  idx_q   <= idx_inc;
                  intt_q  <= mode_q[idx_inc];
               end
               default: state_q <= S_IDLE;
            endcase
      end
   assign core_start_o = start_q;
   assign core_intt_o  = intt_q;
   assign busy_o       = busy_q;
   assign done_o       = done_q;
   assign error_o      = error_q;
   assign poly_idx_o   = idx_q;
   assign cycles_o     = cycles_q;
   assign mem_raddr_o  = {idx_q, core_raddr_i};
   assign mem_waddr_o  = {idx_q, core_waddr_i};
   // gated by rst so a reset cycle never issues a write
   assign mem_we_o     = core_wea_i && (state_q == S_RUN) && rst;
   assign mem_wdata_o  = core_dout_i;
   assign core_din_o   = mem_rdata_i;
endmodule

// File: tb/tb_ntt_batch_sequencer.sv
// tb_ntt_batch_sequencer: randomized directed bench with a timeline model of each batch
module tb_ntt_batch_sequencer;
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;
   logic start_i = 1'b0, start_to = 1'b0, abort_i = 1'b0;
   logic [2:0] npoly_i = '0;
   logic [3:0] mode_i = '0;
   logic [9:0] raddr = '0, waddr = '0;
   logic wea = 1'b0;
   logic [15:0] dout = '0, rdata = '0;
   logic cs, intt, busy, done, err, mwe;
   logic [1:0] idx;
   logic [63:0] cyc;
   logic [11:0] mra, mwa;
   logic [15:0] din, mwd;
   logic cs_t, intt_t, busy_t, done_t, err_t, mwe_t;
   logic [1:0] idx_t;
   logic [63:0] cyc_t;
   logic [11:0] mra_t, mwa_t;
   logic [15:0] din_t, mwd_t;
   int n_err = 0, n_chk = 0;
   int cur_lat = 1000;
   int cnt = 0;
   logic fin = 1'b0;

   // core model: raises finish cur_lat cycles after start goes high, holds it until start drops
   always @(posedge clk)
      if (!cs) begin
         cnt <= 0;
         fin <= 1'b0;
      end else begin
         cnt <= cnt + 1;
         if (cnt + 1 == cur_lat) fin <= 1'b1;
      end

   ntt_batch_sequencer #(.LOGN(4), .LOGQ(16), .NPOLY(4), .TIMEOUT(128)) dut (
      .clk(clk), .rst(rst), .start_i(start_i), .abort_i(abort_i), .npoly_i(npoly_i),
      .mode_mask_i(mode_i), .core_start_o(cs), .core_intt_o(intt), .core_raddr_i(raddr),
      .core_waddr_i(waddr), .core_wea_i(wea), .core_finish_i(fin), .core_din_o(din),
      .core_dout_i(dout), .mem_raddr_o(mra), .mem_waddr_o(mwa), .mem_we_o(mwe),
      .mem_rdata_i(rdata), .mem_wdata_o(mwd), .busy_o(busy), .done_o(done), .error_o(err),
      .poly_idx_o(idx), .cycles_o(cyc));

   ntt_batch_sequencer #(.LOGN(4), .LOGQ(16), .NPOLY(4), .TIMEOUT(64)) dut_to (
      .clk(clk), .rst(rst), .start_i(start_to), .abort_i(abort_i), .npoly_i(npoly_i),
      .mode_mask_i(mode_i), .core_start_o(cs_t), .core_intt_o(intt_t), .core_raddr_i(raddr),
      .core_waddr_i(waddr), .core_wea_i(wea), .core_finish_i(1'b0), .core_din_o(din_t),
      .core_dout_i(dout), .mem_raddr_o(mra_t), .mem_waddr_o(mwa_t), .mem_we_o(mwe_t),
      .mem_rdata_i(rdata), .mem_wdata_o(mwd_t), .busy_o(busy_t), .done_o(done_t), .error_o(err_t),
      .poly_idx_o(idx_t), .cycles_o(cyc_t));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // each polynomial k occupies L[k]+2 cycles: LAUNCH, L[k] RUN cycles, GAP; DONE follows the last
   task automatic batch(input int n, input logic [3:0] mm, input int lat_fix);
      int L[4];
      int base[4];
      int tot, k, off;
      tot = 0;
      for (int j = 0; j < n; j++) begin
         L[j] = (lat_fix > 0) ? lat_fix : int'($urandom_range(1, 12));
         base[j] = tot;
         tot += L[j] + 2;
      end
      start_i = 1'b1;
      npoly_i = 3'(n);
      mode_i = mm;
      step();
      for (int t = 0; t <= tot; t++) begin
         k = n - 1;
         off = L[n-1] + 2;
         for (int j = 0; j < n; j++)
            if (t >= base[j] && t < base[j] + L[j] + 2) begin
               k = j;
               off = t - base[j];
            end
         if (off == 0) cur_lat = L[k];
         start_i = 1'($urandom_range(0, 1));
         npoly_i = 3'($urandom_range(0, 4));
         mode_i = 4'($urandom);
         raddr = 10'($urandom);
         waddr = (off == 3) ? 10'd5 : 10'($urandom);
         wea = (off == 3) ? 1'b1 : 1'($urandom);
         dout = 16'($urandom);
         rdata = 16'($urandom);
         #1;
         chk("busy", busy, t < tot);
         chk("done", done, t == tot);
         chk("core_start", cs, t < tot && off <= L[k]);
         chk("poly_idx", idx, k);
         chk("cycles", cyc, t);
         chk("error", err, 0);
         if (t < tot) chk("core_intt", intt, mm[k]);
         chk("mem_we", mwe, wea && t < tot && off >= 1 && off <= L[k]);
         chk("mem_waddr", mwa, k * 1024 + int'(waddr));
         chk("mem_raddr", mra, k * 1024 + int'(raddr));
         chk("core_din", din, rdata);
         chk("mem_wdata", mwd, dout);
         step();
      end
      start_i = 1'b0;
      wea = 1'b0;
      chk("cycles_hold", cyc, tot);
      chk("idle_done", done, 0);
      chk("idle_busy", busy, 0);
   endtask

   initial begin
      step();
      step();
      chk("rst_core_start", cs, 0);
      chk("rst_intt", intt, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_error", err, 0);
      chk("rst_idx", idx, 0);
      chk("rst_cycles", cyc, 0);
      chk("rst_to_busy", busy_t, 0);
      rst = 1'b1;
      step();
      // empty batch: straight to DONE
      start_i = 1'b1;
      npoly_i = 3'd0;
      step();
      start_i = 1'b0;
      chk("n0_done", done, 1);
      chk("n0_busy", busy, 0);
      chk("n0_cycles", cyc, 0);
      chk("n0_start", cs, 0);
      step();
      chk("n0_done_end", done, 0);
      chk("n0_busy_end", busy, 0);
      step();
      batch(3, 4'b0010, 100);
      chk("cycles_306", cyc, 306);
      for (int r = 0; r < 4; r++) begin
         batch(int'($urandom_range(1, 4)), 4'($urandom), 0);
         step();
      end
      // abort during RUN of poly 1 (poly 1 RUN spans t=13..22 with latency 10)
      cur_lat = 10;
      start_i = 1'b1;
      npoly_i = 3'd3;
      mode_i = 4'b0101;
      step();
      start_i = 1'b0;
      repeat (15) step();
      chk("ab_pre_start", cs, 1);
      chk("ab_pre_idx", idx, 1);
      abort_i = 1'b1;
      step();
      abort_i = 1'b0;
      chk("ab_start", cs, 0);
      chk("ab_error", err, 1);
      chk("ab_done", done, 1);
      chk("ab_busy", busy, 0);
      chk("ab_idx", idx, 1);
      step();
      chk("ab_done_end", done, 0);
      chk("ab_err_hold", err, 1);
      chk("ab_idx_hold", idx, 1);
      abort_i = 1'b1;
      step();
      abort_i = 1'b0;
      chk("ab_idle_ignored", err, 1);
      chk("ab_idle_done", done, 0);
      batch(2, 4'($urandom), 0);
      step();
      // watchdog: core never finishes, TIMEOUT=64
      start_to = 1'b1;
      npoly_i = 3'd2;
      mode_i = 4'b0001;
      step();
      start_to = 1'b0;
      for (int t = 0; t <= 65; t++) begin
         chk("to_start", cs_t, t < 65);
         chk("to_done", done_t, t == 65);
         chk("to_error", err_t, t == 65);
         chk("to_cycles", cyc_t, t);
         if (t == 0) chk("to_intt", intt_t, 1);
         step();
      end
      chk("to_err_hold", err_t, 1);
      chk("to_idx", idx_t, 0);
      chk("to_busy", busy_t, 0);
      // reset in the middle of RUN with a write pending
      cur_lat = 20;
      start_i = 1'b1;
      npoly_i = 3'd4;
      mode_i = 4'b1111;
      step();
      start_i = 1'b0;
      repeat (5) step();
      chk("pre_rst_start", cs, 1);
      wea = 1'b1;
      rst = 1'b0;
      #1;
      chk("rst_mem_we", mwe, 0);
      step();
      chk("mr_core_start", cs, 0);
      chk("mr_intt", intt, 0);
      chk("mr_busy", busy, 0);
      chk("mr_done", done, 0);
      chk("mr_error", err, 0);
      chk("mr_idx", idx, 0);
      chk("mr_cycles", cyc, 0);
      chk("mr_mem_we", mwe, 0);
      chk("mr_to_error", err_t, 0);
      wea = 1'b0;
      rst = 1'b1;
      step();
      batch(int'($urandom_range(1, 4)), 4'($urandom), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
